// File: rtl/gpu_pkg.sv
// Shared command codes, FSM encoding and timing constants for the
// text-mode GPU command writer.
package gpu_pkg;

    typedef enum logic [1:0] {
        CMD_CHAR  = 2'b00,
        CMD_CLEAR = 2'b01,
        CMD_COLOR = 2'b10,
        CMD_RSVD  = 2'b11
    } cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_SETUP   = 2'b01,
        ST_STROBE  = 2'b10,
        ST_RECOVER = 2'b11
    } state_e;

    typedef struct packed {
        cmd_e       cmd;
        logic [6:0] data;
    } cmd_entry_t;

    localparam int               CNT_W       = 13;
    // Clearing 4800 cells keeps the GPU busy for 4802 bus ticks.
    localparam logic [CNT_W-1:0] CLEAR_TICKS = 13'd4802;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with power-of-two depth; the extra pointer bit
// distinguishes full from empty.
module sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q, wptr_d, rptr_q, rptr_d;
    logic             wr_en, rd_en;

    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty_o = (wptr_q == rptr_q);
    // Full is registered, so a same-cycle pop never frees room for a push.
    assign wr_en   = push_i & ~full_o;
    assign rd_en   = pop_i & ~empty_o;
    assign wptr_d  = wptr_q + (AW+1)'(wr_en);
    assign rptr_d  = rptr_q + (AW+1)'(rd_en);
    assign dout_o  = mem_q[rptr_q[AW-1:0]];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) mem_q[wptr_q[AW-1:0]] <= din_i;
    end

endmodule

// File: rtl/gpu_cmd_writer.sv
// Buffers host commands and replays them as strobed writes on the slow
// text-mode GPU bus (GPU_CLK = CLK/2, GPU samples on the falling edge).
module gpu_cmd_writer
    import gpu_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       IN_VALID,
    input  logic [1:0] IN_CMD,
    input  logic [7:0] IN_DATA,
    output logic       IN_READY,
    output logic       GPU_CLK,
    output logic       GPU_CE,
    output logic       GPU_RW,
    output logic [1:0] GPU_ADDR,
    output logic [6:0] GPU_DATA,
    output logic       BUSY
);
    state_e           state_q, state_d;
    logic             gclk_q;
    logic             ce_q, ce_d, rw_q, rw_d;
    logic [1:0]       addr_q, addr_d;
    logic [6:0]       data_q, data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    cmd_entry_t       wr_entry, rd_entry;
    logic             full, empty, push, pop, tick;
    logic             unused_data7;

    assign unused_data7 = IN_DATA[7];
    assign wr_entry     = '{cmd: cmd_e'(IN_CMD), data: IN_DATA[6:0]};
    assign push         = IN_VALID & IN_READY;
    // Bus state only moves as GPU_CLK rises, leaving a full CLK of settle
    // time before the GPU samples on the falling edge.
    assign tick         = ~gclk_q;

    sync_fifo #(
        .WIDTH($bits(cmd_entry_t)),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk_i  (CLK),
        .rst_i  (RST),
        .push_i (push),
        .din_i  (wr_entry),
        .pop_i  (pop),
        .dout_o (rd_entry),
        .full_o (full),
        .empty_o(empty)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            gclk_q  <= 1'b0;
            state_q <= ST_IDLE;
            ce_q    <= 1'b1;
            rw_q    <= 1'b1;
            addr_q  <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            gclk_q  <= ~gclk_q;
            state_q <= state_d;
            ce_q    <= ce_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ce_d    = ce_q;
        rw_d    = rw_q;
        addr_d  = addr_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        pop     = 1'b0;
        if (tick) begin
            case (state_q)
                ST_IDLE: begin
                    rw_d = 1'b1;
                    if (!empty) begin
                        pop = 1'b1;
                        // Reserved entries are dropped here without touching the bus.
                        if (rd_entry.cmd != CMD_RSVD) begin
                            addr_d  = rd_entry.cmd;
                            data_d  = rd_entry.data;
                            rw_d    = 1'b0;
                            ce_d    = 1'b1;
                            state_d = ST_SETUP;
                        end
                    end
                end
                ST_SETUP: begin
                    ce_d    = 1'b0;
                    state_d = ST_STROBE;
                end
                ST_STROBE: begin
                    ce_d    = 1'b1;
                    cnt_d   = (addr_q == CMD_CLEAR) ? CLEAR_TICKS : CNT_W'(1);
                    state_d = ST_RECOVER;
                end
                ST_RECOVER: begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q <= CNT_W'(1)) begin
                        cnt_d   = '0;
                        rw_d    = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign IN_READY = ~RST & ~full;
    assign BUSY     = ~RST & (~empty | (state_q != ST_IDLE));
    assign GPU_CLK  = gclk_q;
    assign GPU_CE   = ce_q;
    assign GPU_RW   = rw_q;
    assign GPU_ADDR = addr_q;
    assign GPU_DATA = data_q;

endmodule

// File: tb/tb_gpu_cmd_writer.sv
// Bench for gpu_cmd_writer: a tick-timeline reference model checked every
// cycle, a GPU screen model on the bus, and directed plus random stimulus.
module tb_gpu_cmd_writer;
    localparam int DEPTH = 8;
    localparam int CLR   = 4802;

    logic       CLK = 1'b0, RST = 1'b1, IN_VALID = 1'b0;
    logic [1:0] IN_CMD = 2'b00;
    logic [7:0] IN_DATA = 8'h00;
    logic       IN_READY, GPU_CLK, GPU_CE, GPU_RW, BUSY;
    logic [1:0] GPU_ADDR;
    logic [6:0] GPU_DATA;
    int         total = 0, bad = 0;

    gpu_cmd_writer #(.FIFO_DEPTH(DEPTH)) dut (
        .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_CMD(IN_CMD), .IN_DATA(IN_DATA),
        .IN_READY(IN_READY), .GPU_CLK(GPU_CLK), .GPU_CE(GPU_CE), .GPU_RW(GPU_RW),
        .GPU_ADDR(GPU_ADDR), .GPU_DATA(GPU_DATA), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @%0t: got %0h want %0h", nm, $time, act, exp);
        end
    endtask

    // Reference model: accepted entries queue up; a write popped at tick p
    // strobes CE at tick p+1, frees the bus at tick p+2+rec and the next pop
    // may happen at tick p+3+rec.
    logic [8:0] mq[$];
    bit         m_on = 0, m_gclk, m_ce, m_rw, have_wr;
    logic [1:0] m_addr;
    logic [6:0] m_data;
    int         tk, p, rec, next_pop, cyc_cnt = 0;

    task automatic model_step();
        logic [8:0] e, h;
        bit         acc;
        cyc_cnt++;
        if (RST) begin
            mq.delete();
            m_on = 1; m_gclk = 0; m_ce = 1; m_rw = 1; m_addr = 0; m_data = 0;
            have_wr = 0; tk = -1; next_pop = 0; p = 0; rec = 0;
            return;
        end
        if (!m_on) return;
        acc = IN_VALID && (mq.size() < DEPTH);
        e   = {IN_CMD, IN_DATA[6:0]};
        if (!m_gclk) begin
            tk++;
            if (have_wr) begin
                m_ce = (tk != p + 1);
                m_rw = (tk >= p + 2 + rec);
            end
            if (tk >= next_pop && mq.size() > 0) begin
                h = mq.pop_front();
                if (h[8:7] != 2'b11) begin
                    p = tk; rec = (h[8:7] == 2'b01) ? CLR : 1; have_wr = 1;
                    m_addr = h[8:7]; m_data = h[6:0]; m_rw = 0; m_ce = 1;
                    next_pop = tk + 3 + rec;
                end
            end
        end
        m_gclk = !m_gclk;
        if (acc) mq.push_back(e);
    endtask

    initial forever begin
        @(posedge CLK);
        model_step();
    end

    initial forever begin
        bit exp_rdy, exp_busy;
        @(negedge CLK);
        if (m_on) begin
            exp_rdy  = !RST && (mq.size() < DEPTH);
            exp_busy = !RST && (mq.size() > 0 || (have_wr && tk < p + 2 + rec));
            check("bus", {GPU_CLK, GPU_CE, GPU_RW, GPU_ADDR, GPU_DATA, IN_READY, BUSY},
                         {m_gclk, m_ce, m_rw, m_addr, m_data, exp_rdy, exp_busy});
        end
    end

    // GPU model: samples the bus on GPU_CLK falling edges.
    logic [6:0] scr [4800];
    int         cur = 0;
    bit         prev_low = 0;
    int         s_cyc[$];
    logic [8:0] s_ent[$];

    task automatic gpu_reset();
        foreach (scr[i]) scr[i] = 7'h00;
        cur = 0;
    endtask

    initial forever begin
        @(negedge GPU_CLK);
        #1;
        if (GPU_CE === 1'b0) begin
            check("ce_consecutive", prev_low, 0);
            check("strobe_rw", GPU_RW, 0);
            s_cyc.push_back(cyc_cnt);
            s_ent.push_back({GPU_ADDR, GPU_DATA});
            case (GPU_ADDR)
                2'b00: begin scr[cur] = GPU_DATA; cur = (cur + 1) % 4800; end
                2'b01: begin foreach (scr[i]) scr[i] = 7'h00; cur = 0; end
                default: ;
            endcase
            prev_low = 1;
        end else begin
            prev_low = 0;
        end
    end

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic push(input logic [1:0] c, input logic [7:0] d, input int budget);
        int n = 0;
        IN_VALID = 1'b1; IN_CMD = c; IN_DATA = d;
        while (!IN_READY && n < budget) begin cyc(); n++; end
        check("push_accept", IN_READY, 1);
        cyc();
        IN_VALID = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output int fall_cyc);
        int n = 0;
        while (BUSY && n < budget) begin cyc(); n++; end
        check("idle_timeout", BUSY, 0);
        fall_cyc = cyc_cnt;
    endtask

    task automatic wait_ce_low(input int budget);
        int n = 0;
        while (GPU_CE && n < budget) begin cyc(); n++; end
        check("ce_low_seen", GPU_CE, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int  k, f, r;
        bit  ce_low;
        repeat (3) cyc();
        check("rst_gclk", GPU_CLK, 0);
        check("rst_ce", GPU_CE, 1);
        check("rst_rw", GPU_RW, 1);
        check("rst_addr_data", {GPU_ADDR, GPU_DATA}, 0);
        check("rst_ready", IN_READY, 0);
        check("rst_busy", BUSY, 0);
        RST = 1'b0;
        #1;
        check("ready_after_rst", IN_READY, 1);

        // Single char write; BUSY falls three CLKs after the GPU samples it.
        gpu_reset();
        k = s_cyc.size();
        push(2'b00, 8'h41, 20);
        wait_idle(200, f);
        check("a_strobe_count", s_cyc.size() - k, 1);
        if (s_cyc.size() == k + 1) begin
            check("a_entry", s_ent[k], {2'b00, 7'h41});
            check("a_busy_fall", f - s_cyc[k], 3);
        end
        check("a_screen", scr[0], 7'h41);

        // Back-to-back chars strobe four ticks (eight CLKs) apart.
        gpu_reset();
        k = s_cyc.size();
        push(2'b00, 8'h48, 20);
        push(2'b00, 8'h49, 20);
        wait_idle(200, f);
        check("hi_strobe_count", s_cyc.size() - k, 2);
        if (s_cyc.size() == k + 2) check("hi_spacing", s_cyc[k+1] - s_cyc[k], 8);
        check("hi_screen0", scr[0], 7'h48);
        check("hi_screen1", scr[1], 7'h49);

        // Clear stalls the bus; nine chars queue behind it, the ninth waits.
        gpu_reset();
        k = s_cyc.size();
        push(2'b01, 8'h00, 20);
        wait_ce_low(40);
        for (int i = 0; i < 8; i++) push(2'b00, (8'h58 + 8'(i)) | (i[0] ? 8'h80 : 8'h00), 20);
        check("full_after_8", IN_READY, 0);
        push(2'b00, 8'h60, 12000);
        wait_idle(12000, f);
        check("clr_strobe_count", s_cyc.size() - k, 10);
        if (s_cyc.size() == k + 10) begin
            check("clr_entry", s_ent[k][8:7], 2'b01);
            check("clr_gap", s_cyc[k+1] - s_cyc[k], 2 * (CLR + 3));
        end
        for (int i = 0; i < 9; i++) check("clr_screen", scr[i], 7'(8'h58 + 8'(i)));

        // Reset during the strobe drops the command; reserved entries stay off the bus.
        push(2'b00, 8'h5A, 20);
        wait_ce_low(40);
        RST = 1'b1;
        cyc();
        check("rst_mid_ce", GPU_CE, 1);
        check("rst_mid_ready", IN_READY, 0);
        check("rst_mid_busy", BUSY, 0);
        cyc();
        RST = 1'b0;
        #1;
        check("rst_release_ready", IN_READY, 1);
        k = s_cyc.size();
        push(2'b11, 8'h55, 20);
        ce_low = 0;
        repeat (30) begin cyc(); if (!GPU_CE) ce_low = 1; end
        check("rsvd_no_ce", ce_low, 0);
        check("rsvd_no_strobe", s_cyc.size() - k, 0);
        check("rsvd_idle", BUSY, 0);

        // Random traffic with occasional reset pulses.
        for (int i = 0; i < 600; i++) begin
            r        = $urandom_range(0, 9);
            IN_VALID = ($urandom_range(0, 2) == 0);
            IN_CMD   = (r < 6) ? 2'b00 : ((r < 8) ? 2'b10 : 2'b11);
            IN_DATA  = 8'($urandom);
            RST      = ($urandom_range(0, 249) == 0);
            cyc();
        end
        IN_VALID = 1'b0;
        RST      = 1'b0;
        cyc();
        wait_idle(2000, f);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
